uart_apb_host: RTL and testbench

// - APB initiator (bus master) that drives the UART APB peripheral from the processor side.
// - Configures the peripheral's baud-divider and control registers, then polls the status register.
// - Moves bytes between simple valid/ready byte streams and the peripheral's TX/RX data registers.
// - Used for boot-time console and DMA-less test traffic in the SoC.

---
 rtl/uart_apb_pkg.sv | 42 ++++
 rtl/uart_apb_host_xfer.sv | 101 ++++++++++
 rtl/uart_apb_host.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_apb_host.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB host: register map, status bits,
// error bit indices and the state encodings of host and transfer engine.
package uart_apb_pkg;

  localparam logic [7:0] BAUD_OFS   = 8'h00;
  localparam logic [7:0] CTRL_OFS   = 8'h04;
  localparam logic [7:0] STATUS_OFS = 8'h08;
  localparam logic [7:0] TXDATA_OFS = 8'h0C;
  localparam logic [7:0] RXDATA_OFS = 8'h10;

  localparam int unsigned STAT_TXFULL  = 0;
  localparam int unsigned STAT_RXEMPTY = 3;

  localparam int unsigned ERR_SLVERR  = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

  // Arbitration memory: which side won the last RX/TX grant
  localparam logic GRANT_RX = 1'b0;
  localparam logic GRANT_TX = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_BAUD,
    ST_CFG_CTRL,
    ST_POLL,
    ST_RD_RX,
    ST_WR_TX,
    ST_GAP
  } host_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } xfer_phase_t;

  // Zero-extend a byte into a 32-bit register word
  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'd0, b};
  endfunction

endpackage

// File: rtl/uart_apb_host_xfer.sv
// Single APB transfer engine: SETUP/ACCESS sequencing with an ACCESS-phase
// timeout. Completion flags are combinational on the completion cycle.
module apb_master_xfer
  import uart_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATAW      = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRSTn,
  input  logic                  i_req,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATAW-1:0]      i_wdata,
  input  logic [DATAW-1:0]      i_prdata,
  input  logic                  i_pready,
  input  logic                  i_pslverr,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [ADDR_WIDTH-1:0] o_paddr,
  output logic [DATAW-1:0]      o_pwdata,
  output logic                  o_done,
  output logic                  o_fail,
  output logic                  o_slverr,
  output logic [DATAW-1:0]      o_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  xfer_phase_t           r_phase;
  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATAW-1:0]      r_pwdata;
  logic [TW-1:0]         r_timer;
  logic                  w_access;
  logic                  w_tmo;

  assign w_access = (r_phase == PH_ACCESS);
  // Timer counts ACCESS cycles from 0, so the last allowed cycle is TIMEOUT-1
  assign w_tmo    = w_access && !i_pready && (r_timer == TMO_LAST);

  assign o_done    = w_access && i_pready;
  assign o_fail    = w_tmo;
  assign o_slverr  = w_access && i_pready && i_pslverr;
  assign o_rdata   = i_prdata;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwrite  = r_pwrite;
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;

  // Transfer phase sequencing; address/data/direction latched at SETUP
  always_ff @(posedge PCLK or negedge PRSTn) begin
    if (!PRSTn) begin
      r_phase   <= PH_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_timer   <= '0;
    end else begin
      unique case (r_phase)
        PH_IDLE: begin
          if (i_req) begin
            r_phase  <= PH_SETUP;
            r_psel   <= 1'b1;
            r_pwrite <= i_wr;
            r_paddr  <= i_addr;
            r_pwdata <= i_wdata;
          end
        end
        PH_SETUP: begin
          r_phase   <= PH_ACCESS;
          r_penable <= 1'b1;
          r_timer   <= '0;
        end
        PH_ACCESS: begin
          if (i_pready || w_tmo) begin
            r_phase   <= PH_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_phase   <= PH_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_apb_host.sv
// APB initiator for the UART peripheral: configures BAUD/CTRL, then polls
// STATUS and moves bytes between the byte streams and TXDATA/RXDATA.
module uart_apb_host
  import uart_apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    APB_DATAW  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    TIMEOUT    = 16,
  parameter int                    POLL_GAP   = 4
) (
  input  logic                  PCLK,
  input  logic                  PRSTn,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATAW-1:0]  PWDATA,
  input  logic [APB_DATAW-1:0]  PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic                  cfg_start,
  input  logic [31:0]           cfg_ctrl,
  input  logic [7:0]            cfg_baud,
  input  logic [7:0]            tx_byte,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [7:0]            rx_byte,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic [1:0]            err,
  input  logic                  err_clr
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);

  host_state_t           r_state;
  logic [7:0]            r_cfg_baud;
  logic [31:0]           r_cfg_ctrl;
  logic                  r_last_grant;
  logic [GW-1:0]         r_gap_cnt;
  logic [7:0]            r_rx_byte;
  logic                  r_rx_valid;
  logic [1:0]            r_err;

  logic                  w_req;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [APB_DATAW-1:0]  w_wdata;
  logic                  w_done;
  logic                  w_fail;
  logic                  w_slverr;
  logic [APB_DATAW-1:0]  w_rdata;
  logic                  w_end;
  logic                  w_bad;
  logic                  w_rx_q;
  logic                  w_tx_q;
  logic                  w_pick_rx;
  logic                  w_pick_tx;
  logic [1:0]            w_err_set;
  logic                  w_unused_rdata;

  apb_master_xfer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATAW      (APB_DATAW),
    .TIMEOUT    (TIMEOUT)
  ) u_xfer (
    .PCLK      (PCLK),
    .PRSTn     (PRSTn),
    .i_req     (w_req),
    .i_wr      (w_wr),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .i_prdata  (PRDATA),
    .i_pready  (PREADY),
    .i_pslverr (PSLVERR),
    .o_psel    (PSEL),
    .o_penable (PENABLE),
    .o_pwrite  (PWRITE),
    .o_paddr   (PADDR),
    .o_pwdata  (PWDATA),
    .o_done    (w_done),
    .o_fail    (w_fail),
    .o_slverr  (w_slverr),
    .o_rdata   (w_rdata)
  );

  assign w_end          = w_done || w_fail;
  assign w_bad          = w_fail || w_slverr;
  assign w_rx_q         = !w_rdata[STAT_RXEMPTY] && !r_rx_valid;
  assign w_tx_q         = tx_valid && !w_rdata[STAT_TXFULL];
  assign w_unused_rdata = ^w_rdata[APB_DATAW-1:8];

  // RX wins when it qualifies alone or when TX had the previous grant
  assign w_pick_rx = w_rx_q && (!w_tx_q || (r_last_grant == GRANT_TX));
  assign w_pick_tx = w_tx_q && !w_pick_rx;

  assign tx_ready = (r_state == ST_WR_TX) && w_done;
  assign busy     = (r_state != ST_IDLE);
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;
  assign err      = r_err;

  // Transfer request decode per state
  always_comb begin
    w_req   = 1'b0;
    w_wr    = 1'b0;
    w_addr  = BASE_ADDR;
    w_wdata = '0;
    case (r_state)
      ST_CFG_BAUD: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = BASE_ADDR + ADDR_WIDTH'(BAUD_OFS);
        w_wdata = APB_DATAW'(byte_word(r_cfg_baud));
      end
      ST_CFG_CTRL: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = BASE_ADDR + ADDR_WIDTH'(CTRL_OFS);
        w_wdata = APB_DATAW'(r_cfg_ctrl);
      end
      ST_POLL: begin
        w_req  = 1'b1;
        w_addr = BASE_ADDR + ADDR_WIDTH'(STATUS_OFS);
      end
      ST_RD_RX: begin
        w_req  = 1'b1;
        w_addr = BASE_ADDR + ADDR_WIDTH'(RXDATA_OFS);
      end
      ST_WR_TX: begin
        w_req   = 1'b1;
        w_wr    = 1'b1;
        w_addr  = BASE_ADDR + ADDR_WIDTH'(TXDATA_OFS);
        w_wdata = APB_DATAW'(byte_word(tx_byte));
      end
      default: ;
    endcase
  end

  // Sequencer: config, poll, dispatch, RX buffer and gap timing
  always_ff @(posedge PCLK or negedge PRSTn) begin
    if (!PRSTn) begin
      r_state      <= ST_IDLE;
      r_cfg_baud   <= '0;
      r_cfg_ctrl   <= '0;
      r_last_grant <= GRANT_TX;
      r_gap_cnt    <= '0;
      r_rx_byte    <= '0;
      r_rx_valid   <= 1'b0;
    end else begin
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_cfg_baud <= cfg_baud;
            r_cfg_ctrl <= cfg_ctrl;
            r_state    <= ST_CFG_BAUD;
          end
        end
        ST_CFG_BAUD: begin
          if (w_end) r_state <= w_bad ? ST_IDLE : ST_CFG_CTRL;
        end
        ST_CFG_CTRL: begin
          if (w_end) begin
            r_state      <= w_bad ? ST_IDLE : ST_POLL;
            r_last_grant <= GRANT_TX;
          end
        end
        ST_POLL: begin
          if (w_end) begin
            if (!w_bad && w_pick_rx) begin
              r_state      <= ST_RD_RX;
              r_last_grant <= GRANT_RX;
            end else if (!w_bad && w_pick_tx) begin
              r_state      <= ST_WR_TX;
              r_last_grant <= GRANT_TX;
            end else begin
              r_state   <= ST_GAP;
              r_gap_cnt <= GAP_LOAD;
            end
          end
        end
        ST_RD_RX: begin
          if (w_end) begin
            if (!w_bad) begin
              r_rx_byte  <= w_rdata[7:0];
              r_rx_valid <= 1'b1;
            end
            r_state <= ST_POLL;
          end
        end
        ST_WR_TX: begin
          if (w_end) r_state <= ST_POLL;
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) r_state <= ST_POLL;
          else r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Error bits to raise this cycle
  always_comb begin
    w_err_set              = '0;
    w_err_set[ERR_SLVERR]  = w_slverr;
    w_err_set[ERR_TIMEOUT] = w_fail;
  end

  // Sticky error register; a new error wins over a simultaneous clear
  always_ff @(posedge PCLK or negedge PRSTn) begin
    if (!PRSTn) r_err <= '0;
    else        r_err <= (err_clr ? 2'b00 : r_err) | w_err_set;
  end

endmodule

// File: tb/tb_uart_apb_host.sv
module tb_uart_apb_host;

  logic        PCLK = 1'b0;
  logic        PRSTn = 1'b0;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_ctrl = '0;
  logic [7:0]  cfg_baud = '0;
  logic [7:0]  tx_byte = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        busy;
  logic [1:0]  err;
  logic        err_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  // Slave model controls
  logic [31:0] s_status = 32'h08;
  logic [31:0] s_rxdata = 32'h0;
  int          s_wait = 0;
  logic        s_hang = 1'b0;
  logic        s_slverr_tx = 1'b0;
  int          s_wcnt = 0;

  uart_apb_host #(
    .ADDR_WIDTH (32),
    .APB_DATAW  (32),
    .BASE_ADDR  (32'h0),
    .TIMEOUT    (16),
    .POLL_GAP   (4)
  ) dut (
    .PCLK(PCLK), .PRSTn(PRSTn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .cfg_start(cfg_start), .cfg_ctrl(cfg_ctrl), .cfg_baud(cfg_baud),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;

  assign PREADY  = PSEL && PENABLE && !s_hang && (s_wcnt >= s_wait);
  assign PSLVERR = PREADY && s_slverr_tx && PWRITE && (PADDR == 32'h0C);
  assign PRDATA  = (PADDR == 32'h08) ? s_status : (PADDR == 32'h10) ? s_rxdata : 32'h0;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) s_wcnt <= s_wcnt + 1;
    else s_wcnt <= 0;
  end

  // Bus monitor: logs completed transfers and protocol violations
  localparam int LOGN = 4096;
  logic        log_w[LOGN];
  logic [31:0] log_a[LOGN];
  logic [31:0] log_d[LOGN];
  int          log_len[LOGN];
  int          log_n = 0;
  int          cur_len = 0;
  logic [31:0] cap_a = '0, cap_d = '0;
  logic        cap_w = 1'b0;
  logic        prev_done = 1'b0;
  int          stab_err = 0, proto_err = 0, tx_pulses = 0;

  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      cap_a <= PADDR; cap_d <= PWDATA; cap_w <= PWRITE; cur_len <= 1;
    end else if (PSEL && PENABLE) begin
      cur_len <= cur_len + 1;
      if (PADDR !== cap_a || PWDATA !== cap_d || PWRITE !== cap_w) stab_err <= stab_err + 1;
    end
    if ((PENABLE && !PSEL) || (prev_done && PSEL && PENABLE)) proto_err <= proto_err + 1;
    prev_done <= PSEL && PENABLE && PREADY;
    if (PSEL && PENABLE && PREADY && log_n < LOGN) begin
      log_w[log_n]   <= PWRITE;
      log_a[log_n]   <= PADDR;
      log_d[log_n]   <= PWRITE ? PWDATA : PRDATA;
      log_len[log_n] <= cur_len + 1;
      log_n          <= log_n + 1;
    end
    if (tx_ready) tx_pulses <= tx_pulses + 1;
  end

  task automatic test_reset();
    PRSTn = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++; if (PSEL !== 1'b0) begin errors++; $display("FAIL reset_psel: got %b want 0", PSEL); end
    checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b want 0", PENABLE); end
    checks++; if (PWRITE !== 1'b0) begin errors++; $display("FAIL reset_pwrite: got %b want 0", PWRITE); end
    checks++; if (PADDR !== 32'h0) begin errors++; $display("FAIL reset_paddr: got %h want 0", PADDR); end
    checks++; if (PWDATA !== 32'h0) begin errors++; $display("FAIL reset_pwdata: got %h want 0", PWDATA); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_byte !== 8'h0) begin errors++; $display("FAIL reset_rx_byte: got %h want 0", rx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err); end
    PRSTn = 1'b1;
    repeat (5) @(negedge PCLK);
    checks++; if (PSEL !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet: psel=%b busy=%b want 0 0", PSEL, busy); end
  endtask

  task automatic test_config();
    int base, n;
    logic        exp_w[3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] exp_a[3] = '{32'h00, 32'h04, 32'h08};
    logic [31:0] exp_d[3] = '{32'h1A, 32'h1C, 32'h08};
    s_status = 32'h08; tx_valid = 1'b0;
    base = log_n;
    cfg_baud = 8'h1A; cfg_ctrl = 32'h1C; cfg_start = 1'b1;
    @(negedge PCLK);
    cfg_start = 1'b0; cfg_baud = 8'hFF; cfg_ctrl = 32'hFFFF_FFFF;
    n = 0;
    while (log_n < base + 3 && n < 100) begin @(negedge PCLK); n++; end
    checks++; if (log_n < base + 3) begin errors++; $display("FAIL config_wait: got %0d transfers want 3", log_n - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_w[base+i] !== exp_w[i] || log_a[base+i] !== exp_a[i] || log_d[base+i] !== exp_d[i] || log_len[base+i] != 2) begin
        errors++;
        $display("FAIL config_xfer%0d: got w=%b a=%h d=%h len=%0d want w=%b a=%h d=%h len=2",
                 i, log_w[base+i], log_a[base+i], log_d[base+i], log_len[base+i], exp_w[i], exp_a[i], exp_d[i]);
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL config_busy: got %b want 1", busy); end
  endtask

  task automatic test_tx();
    int base, n, p0, ntx, after;
    s_status = 32'h08; tx_byte = 8'h55; tx_valid = 1'b1;
    base = log_n; p0 = tx_pulses;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
    checks++;
    if (tx_ready !== 1'b1 || PADDR !== 32'h0C || PWDATA !== 32'h55 || PWRITE !== 1'b1) begin
      errors++; $display("FAIL tx_write: got ready=%b a=%h d=%h w=%b want 1 0c 55 1", tx_ready, PADDR, PWDATA, PWRITE);
    end
    tx_valid = 1'b0; tx_byte = 8'h00;
    @(negedge PCLK);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_pulse_width: got %b want 0", tx_ready); end
    repeat (30) @(negedge PCLK);
    checks++; if (tx_pulses - p0 != 1) begin errors++; $display("FAIL tx_pulse_count: got %0d want 1", tx_pulses - p0); end
    ntx = 0; after = -1;
    for (int i = base; i < log_n; i++) if (log_w[i] && log_a[i] == 32'h0C) begin ntx++; after = i + 1; end
    checks++; if (ntx != 1) begin errors++; $display("FAIL tx_write_count: got %0d want 1", ntx); end
    checks++;
    if (after < 0 || log_w[after] !== 1'b0 || log_a[after] !== 32'h08) begin
      errors++; $display("FAIL tx_then_poll: got idx=%0d want status read after TX write", after);
    end
  endtask

  task automatic test_rx();
    int base, base2, n, nrx, nst;
    tx_valid = 1'b0; rx_ready = 1'b0; s_rxdata = 32'hA7; s_status = 32'h00;
    base = log_n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
    checks++; if (rx_valid !== 1'b1 || rx_byte !== 8'hA7) begin errors++; $display("FAIL rx_first: got valid=%b byte=%h want 1 a7", rx_valid, rx_byte); end
    repeat (60) @(negedge PCLK);
    checks++; if (rx_valid !== 1'b1 || rx_byte !== 8'hA7) begin errors++; $display("FAIL rx_hold: got valid=%b byte=%h want 1 a7", rx_valid, rx_byte); end
    nrx = 0; nst = 0;
    for (int i = base; i < log_n; i++) begin
      if (log_a[i] == 32'h10) nrx++;
      if (log_a[i] == 32'h08) nst++;
    end
    checks++; if (nrx != 1) begin errors++; $display("FAIL rx_no_overrun: got %0d RXDATA reads want 1", nrx); end
    checks++; if (nst < 3) begin errors++; $display("FAIL rx_polling: got %0d status reads want >=3", nst); end
    s_rxdata = 32'h3C; base2 = log_n;
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_consume: got valid=%b want 0", rx_valid); end
    n = 0;
    while (rx_valid !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
    checks++; if (rx_valid !== 1'b1 || rx_byte !== 8'h3C) begin errors++; $display("FAIL rx_second: got valid=%b byte=%h want 1 3c", rx_valid, rx_byte); end
    repeat (40) @(negedge PCLK);
    nrx = 0;
    for (int i = base2; i < log_n; i++) if (log_a[i] == 32'h10) nrx++;
    checks++; if (nrx != 1) begin errors++; $display("FAIL rx_one_more: got %0d RXDATA reads want 1", nrx); end
    s_status = 32'h08;
    rx_ready = 1'b1;
    @(negedge PCLK);
    rx_ready = 1'b0;
    repeat (10) @(negedge PCLK);
  endtask

  task automatic test_wait_states();
    int base, n, se0, len;
    s_wait = 3; s_status = 32'h08;
    se0 = stab_err; base = log_n;
    tx_byte = 8'h5A; tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin @(negedge PCLK); n++; end
    checks++; if (tx_ready !== 1'b1 || PWDATA !== 32'h5A) begin errors++; $display("FAIL wait_tx: got ready=%b d=%h want 1 5a", tx_ready, PWDATA); end
    tx_valid = 1'b0;
    @(negedge PCLK);
    len = -1;
    for (int i = base; i < log_n; i++) if (log_a[i] == 32'h0C) len = log_len[i];
    checks++; if (len != 5) begin errors++; $display("FAIL wait_len: got %0d PSEL cycles want 5", len); end
    checks++; if (stab_err != se0) begin errors++; $display("FAIL wait_stable: got %0d unstable cycles want 0", stab_err - se0); end
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL wait_err: got %b want 00", err); end
    s_wait = 0;
    repeat (10) @(negedge PCLK);
  endtask

  task automatic test_slverr();
    int n;
    s_slverr_tx = 1'b1; tx_byte = 8'h99; tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin @(negedge PCLK); n++; end
    checks++; if (tx_ready !== 1'b1 || PSLVERR !== 1'b1) begin errors++; $display("FAIL slverr_ready: got ready=%b pslverr=%b want 1 1", tx_ready, PSLVERR); end
    tx_valid = 1'b0;
    @(negedge PCLK);
    s_slverr_tx = 1'b0;
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL slverr_err: got %b want 01", err); end
    repeat (20) @(negedge PCLK);
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL slverr_sticky: got %b want 01", err); end
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL slverr_clr: got %b want 00", err); end
  endtask

  task automatic test_timeout();
    int n, acc, base, bad;
    s_status = 32'h08; tx_valid = 1'b0; s_hang = 1'b1;
    n = 0;
    while (!(PSEL && PENABLE) && n < 50) begin @(negedge PCLK); n++; end
    acc = 0;
    while (PSEL === 1'b1 && PENABLE === 1'b1 && acc < 40) begin acc++; @(negedge PCLK); end
    s_hang = 1'b0;
    checks++; if (acc != 16) begin errors++; $display("FAIL timeout_len: got %0d ACCESS cycles want 16", acc); end
    checks++; if (PSEL !== 1'b0 || err !== 2'b10) begin errors++; $display("FAIL timeout_err: got psel=%b err=%b want 0 10", PSEL, err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy: got %b want 1", busy); end
    err_clr = 1'b1;
    @(negedge PCLK);
    err_clr = 1'b0;
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL timeout_clr: got %b want 00", err); end
    base = log_n;
    cfg_baud = 8'h77; cfg_ctrl = 32'h3; cfg_start = 1'b1;
    @(negedge PCLK);
    cfg_start = 1'b0;
    repeat (40) @(negedge PCLK);
    bad = 0;
    for (int i = base; i < log_n; i++) if (log_w[i] && (log_a[i] == 32'h00 || log_a[i] == 32'h04)) bad++;
    checks++; if (bad != 0 || busy !== 1'b1) begin errors++; $display("FAIL cfg_ignored: got %0d config writes busy=%b want 0 1", bad, busy); end
  endtask

  task automatic test_fairness();
    int base, n, cnt, k;
    logic [31:0] seq[6];
    logic [31:0] exp_a[6] = '{32'h10, 32'h0C, 32'h10, 32'h0C, 32'h10, 32'h0C};
    PRSTn = 1'b0;
    @(negedge PCLK);
    PRSTn = 1'b1;
    s_status = 32'h00; s_rxdata = 32'h42; tx_byte = 8'h11; tx_valid = 1'b1; rx_ready = 1'b1;
    base = log_n;
    cfg_baud = 8'h1A; cfg_ctrl = 32'h1C; cfg_start = 1'b1;
    @(negedge PCLK);
    cfg_start = 1'b0;
    n = 0; cnt = 0;
    while (cnt < 6 && n < 400) begin
      @(negedge PCLK); n++;
      cnt = 0;
      for (int i = base; i < log_n; i++) if (log_a[i] == 32'h0C || log_a[i] == 32'h10) cnt++;
    end
    k = 0;
    for (int i = 0; i < 6; i++) seq[i] = 32'hDEAD;
    for (int i = base; i < log_n; i++) if ((log_a[i] == 32'h0C || log_a[i] == 32'h10) && k < 6) begin seq[k] = log_a[i]; k++; end
    for (int i = 0; i < 6; i++) begin
      checks++; if (seq[i] !== exp_a[i]) begin errors++; $display("FAIL fair_%0d: got addr %h want %h", i, seq[i], exp_a[i]); end
    end
    tx_valid = 1'b0; s_status = 32'h08;
    repeat (20) @(negedge PCLK);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int n;
    s_status = 32'h08; s_hang = 1'b1;
    n = 0;
    while (!(PSEL && PENABLE) && n < 50) begin @(negedge PCLK); n++; end
    checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL rst_mid_wait: got penable=%b want 1", PENABLE); end
    #2 PRSTn = 1'b0;
    #1;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: got psel=%b penable=%b busy=%b want 0 0 0", PSEL, PENABLE, busy);
    end
    s_hang = 1'b0;
    @(negedge PCLK);
    PRSTn = 1'b1;
    repeat (20) @(negedge PCLK);
    checks++; if (PSEL !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got psel=%b busy=%b want 0 0", PSEL, busy); end
  endtask

  task automatic test_protocol();
    checks++; if (proto_err != 0) begin errors++; $display("FAIL apb_protocol: got %0d violations want 0", proto_err); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL apb_stability: got %0d unstable cycles want 0", stab_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_config();
    test_tx();
    test_rx();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_fairness();
    test_reset_mid_access();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
